// File: rtl/debug_unlock_ctrl_if.sv
// Key-word handshake between a debug host and debug_unlock_ctrl.
// A word moves on any cycle where key_valid and key_ready are both high.
interface debug_unlock_ctrl_if;
  logic        key_valid;
  logic [15:0] key_data;
  logic        key_ready;

  modport master (output key_valid, output key_data, input key_ready);
  modport slave  (input key_valid, input key_data, output key_ready);
endinterface

// File: rtl/debug_unlock_ctrl.sv
// Debug unlock controller: a four-word key opens a timed debug window.
// Repeated failures trigger a fixed penalty lockout.
module debug_unlock_ctrl #(
  parameter logic [15:0] KEY_0          = 16'hA5A5,
  parameter logic [15:0] KEY_1          = 16'h3C3C,
  parameter logic [15:0] KEY_2          = 16'hF00F,
  parameter logic [15:0] KEY_3          = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES  = 16,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      unlock_req,
  debug_unlock_ctrl_if.slave        key_bus,
  input  logic                      relock,
  input  logic                      scan_mode,
  output logic                      debug_unlocked,
  output logic                      lockout,
  output logic [1:0]                fail_count
);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    COLLECT  = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam logic [1:0]  FAIL_LIMIT   = 2'(MAX_FAILS);
  localparam logic [15:0] GAP_LIMIT    = 16'(GAP_CYCLES);
  localparam logic [15:0] UNLOCK_LOAD  = 16'(UNLOCK_CYCLES);
  localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        mismatch_q, mismatch_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  fail_q, fail_d;

  logic [15:0] expected_key;
  logic        xfer;
  logic        word_bad;
  logic        attempt_failed;
  logic [1:0]  fail_sat;

  assign key_bus.key_ready = (state_q == COLLECT);
  assign debug_unlocked    = (state_q == UNLOCKED);
  assign lockout           = (state_q == LOCKOUT);
  assign fail_count        = fail_q;

  assign xfer     = key_bus.key_valid && (state_q == COLLECT);
  assign word_bad = (key_bus.key_data != expected_key);
  assign fail_sat = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 2'd1;

  always_comb begin
    expected_key = KEY_0;
    case (idx_q)
      2'd0: expected_key = KEY_0;
      2'd1: expected_key = KEY_1;
      2'd2: expected_key = KEY_2;
      2'd3: expected_key = KEY_3;
      default: expected_key = KEY_0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= LOCKED;
      idx_q      <= 2'd0;
      mismatch_q <= 1'b0;
      gap_q      <= 16'd0;
      timer_q    <= 16'd0;
      fail_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      gap_q      <= gap_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    mismatch_d     = mismatch_q;
    gap_d          = gap_q;
    timer_d        = timer_q;
    fail_d         = fail_q;
    attempt_failed = 1'b0;

    case (state_q)
      LOCKED: begin
        if (unlock_req && !scan_mode) begin
          state_d    = COLLECT;
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
          gap_d      = 16'd0;
        end
      end

      COLLECT: begin
        if (relock || scan_mode) begin
          state_d    = LOCKED;
          idx_d      = 2'd0;
          mismatch_d = 1'b0;
          gap_d      = 16'd0;
        end else if (!xfer && (gap_q + 16'd1 >= GAP_LIMIT)) begin
          attempt_failed = 1'b1;
        end else if (xfer) begin
          gap_d = 16'd0;
          // The verdict waits for the last word so the bad position stays hidden
          if (idx_q == 2'd3) begin
            idx_d      = 2'd0;
            mismatch_d = 1'b0;
            if (mismatch_q || word_bad) begin
              attempt_failed = 1'b1;
            end else begin
              state_d = UNLOCKED;
              fail_d  = 2'd0;
              timer_d = UNLOCK_LOAD;
            end
          end else begin
            idx_d      = idx_q + 2'd1;
            mismatch_d = mismatch_q || word_bad;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      UNLOCKED: begin
        if (relock || scan_mode || (timer_q <= 16'd1)) begin
          state_d = LOCKED;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      LOCKOUT: begin
        if (timer_q <= 16'd1) begin
          state_d = LOCKED;
          timer_d = 16'd0;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: state_d = LOCKED;
    endcase

    if (attempt_failed) begin
      fail_d     = fail_sat;
      idx_d      = 2'd0;
      mismatch_d = 1'b0;
      gap_d      = 16'd0;
      if (fail_sat == FAIL_LIMIT) begin
        state_d = LOCKOUT;
        timer_d = LOCKOUT_LOAD;
      end else begin
        state_d = LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Directed bench for debug_unlock_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debug_unlock_ctrl;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       unlock_req = 1'b0;
  logic       relock = 1'b0;
  logic       scan_mode = 1'b0;
  logic       debug_unlocked;
  logic       lockout;
  logic [1:0] fail_count;

  int checks = 0;
  int failures = 0;

  debug_unlock_ctrl_if key_bus ();

  debug_unlock_ctrl dut (
    .Clk           (Clk),
    .reset         (reset),
    .unlock_req    (unlock_req),
    .key_bus       (key_bus),
    .relock        (relock),
    .scan_mode     (scan_mode),
    .debug_unlocked(debug_unlocked),
    .lockout       (lockout),
    .fail_count    (fail_count)
  );

  always #5 Clk = ~Clk;

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  task automatic start_attempt();
    unlock_req = 1'b1;
    @(negedge Clk);
    unlock_req = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    key_bus.key_valid = 1'b1;
    key_bus.key_data  = w;
    @(negedge Clk);
    key_bus.key_valid = 1'b0;
    key_bus.key_data  = 16'h0000;
  endtask

  task automatic attempt(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
    start_attempt();
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
  endtask

  task automatic test_reset();
    key_bus.key_valid = 1'b0;
    key_bus.key_data  = 16'h0000;
    apply_reset();
    checks++; if (debug_unlocked !== 1'b0) begin failures++; $display("FAIL reset_unlocked actual=%0b required=0", debug_unlocked); end
    checks++; if (lockout !== 1'b0) begin failures++; $display("FAIL reset_lockout actual=%0b required=0", lockout); end
    checks++; if (key_bus.key_ready !== 1'b0) begin failures++; $display("FAIL reset_key_ready actual=%0b required=0", key_bus.key_ready); end
    checks++; if (fail_count !== 2'd0) begin failures++; $display("FAIL reset_fail_count actual=%0d required=0", fail_count); end
  endtask

  task automatic test_unlock();
    int cnt = 0;
    start_attempt();
    checks++; if (key_bus.key_ready !== 1'b1) begin failures++; $display("FAIL unlock_key_ready actual=%0b required=1", key_bus.key_ready); end
    send_word(16'hA5A5);
    send_word(16'h3C3C);
    send_word(16'hF00F);
    send_word(16'h1234);
    checks++; if (debug_unlocked !== 1'b1) begin failures++; $display("FAIL unlock_first_cycle actual=%0b required=1", debug_unlocked); end
    checks++; if (fail_count !== 2'd0) begin failures++; $display("FAIL unlock_fail_count actual=%0d required=0", fail_count); end
    while (debug_unlocked === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge Clk);
    end
    checks++; if (cnt != 16) begin failures++; $display("FAIL unlock_duration actual=%0d required=16", cnt); end
    checks++; if (key_bus.key_ready !== 1'b0) begin failures++; $display("FAIL unlock_exit_ready actual=%0b required=0", key_bus.key_ready); end
  endtask

  task automatic test_wrong_word();
    start_attempt();
    send_word(16'hA5A5);
    send_word(16'h0000);
    send_word(16'hF00F);
    checks++; if (key_bus.key_ready !== 1'b1) begin failures++; $display("FAIL wrong_still_collecting actual=%0b required=1", key_bus.key_ready); end
    send_word(16'h1234);
    checks++; if (debug_unlocked !== 1'b0) begin failures++; $display("FAIL wrong_unlocked actual=%0b required=0", debug_unlocked); end
    checks++; if (fail_count !== 2'd1) begin failures++; $display("FAIL wrong_fail_count actual=%0d required=1", fail_count); end
    checks++; if (key_bus.key_ready !== 1'b0 || lockout !== 1'b0) begin failures++; $display("FAIL wrong_state ready=%0b lockout=%0b required=0/0", key_bus.key_ready, lockout); end
  endtask

  task automatic test_lockout();
    int cnt = 0;
    attempt(16'hFFFF, 16'h3C3C, 16'hF00F, 16'h1234);
    checks++; if (fail_count !== 2'd2) begin failures++; $display("FAIL lockout_second_fail actual=%0d required=2", fail_count); end
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h1235);
    checks++; if (lockout !== 1'b1) begin failures++; $display("FAIL lockout_entry actual=%0b required=1", lockout); end
    checks++; if (fail_count !== 2'd3) begin failures++; $display("FAIL lockout_fail_sat actual=%0d required=3", fail_count); end
    while (lockout === 1'b1 && cnt < 200) begin
      if (cnt == 0) begin unlock_req = 1'b1; relock = 1'b1; scan_mode = 1'b1; end
      if (cnt == 4) begin unlock_req = 1'b0; relock = 1'b0; scan_mode = 1'b0; end
      if (cnt == 10) unlock_req = 1'b1;
      if (cnt == 11) unlock_req = 1'b0;
      cnt++;
      @(negedge Clk);
    end
    checks++; if (cnt != 32) begin failures++; $display("FAIL lockout_duration actual=%0d required=32", cnt); end
    checks++; if (fail_count !== 2'd0) begin failures++; $display("FAIL lockout_exit_fail_count actual=%0d required=0", fail_count); end
    checks++; if (key_bus.key_ready !== 1'b0 || debug_unlocked !== 1'b0) begin failures++; $display("FAIL lockout_exit_state ready=%0b unlocked=%0b required=0/0", key_bus.key_ready, debug_unlocked); end
  endtask

  task automatic test_gap_timeout();
    start_attempt();
    send_word(16'hA5A5);
    send_word(16'h3C3C);
    repeat (7) @(negedge Clk);
    checks++; if (key_bus.key_ready !== 1'b1 || fail_count !== 2'd0) begin failures++; $display("FAIL gap_before_limit ready=%0b fail_count=%0d required=1/0", key_bus.key_ready, fail_count); end
    @(negedge Clk);
    checks++; if (key_bus.key_ready !== 1'b0) begin failures++; $display("FAIL gap_ready_drop actual=%0b required=0", key_bus.key_ready); end
    checks++; if (fail_count !== 2'd1) begin failures++; $display("FAIL gap_fail_count actual=%0d required=1", fail_count); end
  endtask

  task automatic test_relock_collect();
    start_attempt();
    send_word(16'hA5A5);
    relock = 1'b1;
    send_word(16'h3C3C);
    relock = 1'b0;
    checks++; if (key_bus.key_ready !== 1'b0 || fail_count !== 2'd1) begin failures++; $display("FAIL relock_collect ready=%0b fail_count=%0d required=0/1", key_bus.key_ready, fail_count); end
  endtask

  task automatic test_scan_mode();
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h1234);
    checks++; if (debug_unlocked !== 1'b1 || fail_count !== 2'd0) begin failures++; $display("FAIL scan_pre_unlock unlocked=%0b fail_count=%0d required=1/0", debug_unlocked, fail_count); end
    repeat (3) @(negedge Clk);
    scan_mode = 1'b1;
    @(negedge Clk);
    scan_mode = 1'b0;
    checks++; if (debug_unlocked !== 1'b0) begin failures++; $display("FAIL scan_unlocked_exit actual=%0b required=0", debug_unlocked); end
    attempt(16'h0001, 16'h3C3C, 16'hF00F, 16'h1234);
    checks++; if (fail_count !== 2'd1) begin failures++; $display("FAIL scan_setup_fail actual=%0d required=1", fail_count); end
    start_attempt();
    send_word(16'hA5A5);
    send_word(16'h3C3C);
    send_word(16'hF00F);
    scan_mode = 1'b1;
    send_word(16'h1234);
    scan_mode = 1'b0;
    checks++; if (debug_unlocked !== 1'b0 || key_bus.key_ready !== 1'b0) begin failures++; $display("FAIL scan_fourth_word unlocked=%0b ready=%0b required=0/0", debug_unlocked, key_bus.key_ready); end
    checks++; if (fail_count !== 2'd1) begin failures++; $display("FAIL scan_fourth_fail_count actual=%0d required=1", fail_count); end
    @(negedge Clk);
    checks++; if (debug_unlocked !== 1'b0) begin failures++; $display("FAIL scan_stays_locked actual=%0b required=0", debug_unlocked); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    attempt(16'hA5A5, 16'h3C3C, 16'h0000, 16'h1234);
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h0000);
    checks++; if (fail_count !== 2'd2) begin failures++; $display("FAIL midreset_setup actual=%0d required=2", fail_count); end
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h1234);
    repeat (2) @(negedge Clk);
    checks++; if (debug_unlocked !== 1'b1) begin failures++; $display("FAIL midreset_unlocked actual=%0b required=1", debug_unlocked); end
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checks++; if (debug_unlocked !== 1'b0 || lockout !== 1'b0 || key_bus.key_ready !== 1'b0 || fail_count !== 2'd0) begin
      failures++; $display("FAIL midreset_outputs unlocked=%0b lockout=%0b ready=%0b fail_count=%0d required=0/0/0/0", debug_unlocked, lockout, key_bus.key_ready, fail_count);
    end
    start_attempt();
    send_word(16'hA5A5);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checks++; if (key_bus.key_ready !== 1'b0) begin failures++; $display("FAIL midreset_collect actual=%0b required=0", key_bus.key_ready); end
  endtask

  task automatic test_back_to_back();
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h1234);
    relock = 1'b1;
    @(negedge Clk);
    relock = 1'b0;
    checks++; if (debug_unlocked !== 1'b0) begin failures++; $display("FAIL b2b_relock actual=%0b required=0", debug_unlocked); end
    attempt(16'hA5A5, 16'h3C3C, 16'hF00F, 16'h1234);
    checks++; if (debug_unlocked !== 1'b1) begin failures++; $display("FAIL b2b_second_unlock actual=%0b required=1", debug_unlocked); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_word();
    test_lockout();
    test_gap_timeout();
    test_relock_collect();
    test_scan_mode();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_unlock_ctrl.md
DEBUG_UNLOCK_CTRL -- requirements
Module: debug_unlock_ctrl

Interface
REQ-001 SHALL have parameter KEY_0, default 16'hA5A5, expected first key word.
REQ-002 SHALL have parameter KEY_1, default 16'h3C3C, expected second key word.
REQ-003 SHALL have parameter KEY_2, default 16'hF00F, expected third key word.
REQ-004 SHALL have parameter KEY_3, default 16'h1234, expected fourth key word.
REQ-005 SHALL have parameter UNLOCK_CYCLES, default 16, number of cycles debug_unlocked stays high without relock.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 32, duration of the penalty lockout.
REQ-007 SHALL have parameter GAP_CYCLES, default 8, maximum idle cycles allowed between key words.
REQ-008 SHALL have parameter MAX_FAILS, default 3, number of failed attempts that triggers lockout.
REQ-009 Clk  input  1  single clock; all state updates on the rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 unlock_req  input  1  request to start a key sequence.
REQ-012 key_valid  input  1  key word present.
REQ-013 key_data  input  16  key word.
REQ-014 key_ready  output  1  block accepts key word; a transfer occurs when key_valid & key_ready.
REQ-015 relock  input  1  software relock / abort.
REQ-016 scan_mode  input  1  scan active; forces the locked condition.
REQ-017 debug_unlocked  output  1  feeds lockable-register write qualifiers downstream.
REQ-018 lockout  output  1  penalty lockout active.
REQ-019 fail_count  output  2  failed attempts since the last success or lockout exit.

Function
REQ-020 The FSM SHALL have exactly four states: LOCKED, COLLECT, UNLOCKED, LOCKOUT; all outputs are decoded from registered state.
REQ-021 In LOCKED, unlock_req=1 with scan_mode=0 SHALL move the FSM to COLLECT next cycle and clear the word index (2b), the mismatch flag, and the gap counter.
REQ-022 key_ready SHALL be 1 only in COLLECT.
REQ-023 In COLLECT, each transfer SHALL compare key_data with KEY[index], set the sticky mismatch flag on inequality, increment the index, and clear the gap counter.
REQ-024 A mismatch SHALL NOT abort collection early; all four words are always consumed so that the failing position is not revealed.
REQ-025 On the fourth transfer with no mismatch (including the fourth word itself), the FSM SHALL enter UNLOCKED, clear fail_count, and load the unlock timer with UNLOCK_CYCLES.
REQ-026 On the fourth transfer with any mismatch, fail_count SHALL increment; if the new value equals MAX_FAILS the FSM SHALL enter LOCKOUT, otherwise LOCKED.
REQ-027 In COLLECT, a cycle without a transfer SHALL increment the gap counter; reaching GAP_CYCLES SHALL be treated as a failed attempt (same handling as REQ-026).
REQ-028 In COLLECT, relock=1 or scan_mode=1 SHALL return the FSM to LOCKED with no fail_count change; a transfer in the same cycle SHALL be discarded.
REQ-029 debug_unlocked SHALL be 1 exactly while in UNLOCKED, first asserting in the cycle after the fourth transfer.
REQ-030 UNLOCKED SHALL last exactly UNLOCK_CYCLES cycles, then return to LOCKED; relock=1 or scan_mode=1 SHALL exit to LOCKED immediately (debug_unlocked=0 next cycle).
REQ-031 unlock_req SHALL be ignored in COLLECT, UNLOCKED, and LOCKOUT.
REQ-032 lockout SHALL be 1 exactly while in LOCKOUT; LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles regardless of relock or scan_mode, then go to LOCKED with fail_count=0.
REQ-033 fail_count SHALL saturate at MAX_FAILS and never wrap.
REQ-034 Priority within any cycle SHALL be: reset > scan_mode/relock > gap timeout > transfer.

Reset
REQ-035 With reset=1 at a clock edge, the FSM SHALL go to LOCKED; debug_unlocked, lockout, key_ready, fail_count, the index, the timers, and the mismatch flag SHALL all be 0 on the next cycle, including when reset arrives mid-COLLECT, mid-UNLOCKED, or mid-LOCKOUT.

Verification
REQ-036 Correct unlock: unlock_req, then A5A5/3C3C/F00F/1234 back-to-back -> debug_unlocked=1 on the cycle after the 4th word for exactly 16 cycles, fail_count=0.
REQ-037 Wrong word: sequence A5A5/0000/F00F/1234 -> all 4 words accepted, debug_unlocked stays 0, fail_count=1, state LOCKED.
REQ-038 Three failures -> lockout=1 for exactly 32 cycles; unlock_req during lockout is ignored; afterwards fail_count=0.
REQ-039 Gap timeout: 2 correct words then 8 idle cycles -> fail_count increments and key_ready drops.
REQ-040 scan_mode pulses while UNLOCKED -> debug_unlocked=0 next cycle; scan_mode coincident with the 4th correct word -> remains locked, fail_count unchanged.
REQ-041 reset asserted mid-UNLOCKED with fail_count=2 beforehand -> all outputs 0 next cycle.
